// File: rtl/vga_timing_gen_if.sv
// Timing-set reload channel for vga_timing_gen: valid/ready offer of a horizontal and
// vertical timing set, plus a one-cycle reject pulse.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 11
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [4*CW-1:0] cfg_h;
  logic [4*CW-1:0] cfg_v;
  logic            cfg_err;

  modport master (
    output cfg_valid,
    output cfg_h,
    output cfg_v,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_h,
    input  cfg_v,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Reprogrammable VGA raster timing generator. New timing sets are staged in a pending
// register and go live only on the last pixel of a frame; video strobes are delayed PIPE cycles.
module vga_timing_gen #(
  parameter int unsigned CW        = 11,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYN     = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYN     = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned PIPE      = 2
) (
  input  logic              vgaclk,
  input  logic              reset,
  vga_timing_gen_if.slave   cfg,
  output logic [CW-1:0]     hcnt,
  output logic [CW-1:0]     vcnt,
  output logic              hsync,
  output logic              vsync,
  output logic              sync_b,
  output logic              blank_b,
  output logic              line_start,
  output logic              frame_start
);

  localparam logic [CW-1:0] HtRst = CW'(H_ACTIVE + H_FP + H_SYN + H_BP);
  localparam logic [CW-1:0] VtRst = CW'(V_ACTIVE + V_FP + V_SYN + V_BP);
  localparam logic [CW+1:0] TotMax = (CW+2)'((2 ** CW) - 1);
  localparam logic [5:0] IdleVec = {~HSYNC_POL, ~VSYNC_POL, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef enum logic [0:0] {StIdle, StPend} cfg_state_e;

  cfg_state_e state_q;
  logic       ready_q, err_q;

  // Back porch lives only inside the stored totals; it has no other use in the raster.
  logic [CW-1:0] ha_q, hf_q, hs_q, ht_q;
  logic [CW-1:0] va_q, vf_q, vs_q, vt_q;
  logic [3*CW-1:0] pend_h_q, pend_v_q;
  logic [CW-1:0]   pend_ht_q, pend_vt_q;

  logic [CW-1:0] hcnt_q, vcnt_q;
  logic [CW+1:0] h_sum, v_sum;
  logic          set_ok;
  logic          h_last, frame_last;

  always_comb begin
    h_sum  = '0;
    v_sum  = '0;
    set_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      h_sum = h_sum + (CW+2)'(cfg.cfg_h[i*CW +: CW]);
      v_sum = v_sum + (CW+2)'(cfg.cfg_v[i*CW +: CW]);
      if (cfg.cfg_h[i*CW +: CW] == '0 || cfg.cfg_v[i*CW +: CW] == '0) set_ok = 1'b0;
    end
    if (h_sum > TotMax || v_sum > TotMax) set_ok = 1'b0;
  end

  assign h_last     = (hcnt_q == ht_q - CW'(1));
  assign frame_last = h_last && (vcnt_q == vt_q - CW'(1));

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (h_last) begin
      hcnt_q <= '0;
      vcnt_q <= frame_last ? '0 : vcnt_q + CW'(1);
    end else begin
      hcnt_q <= hcnt_q + CW'(1);
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      ha_q      <= CW'(H_ACTIVE);
      hf_q      <= CW'(H_FP);
      hs_q      <= CW'(H_SYN);
      ht_q      <= HtRst;
      va_q      <= CW'(V_ACTIVE);
      vf_q      <= CW'(V_FP);
      vs_q      <= CW'(V_SYN);
      vt_q      <= VtRst;
      pend_h_q  <= '0;
      pend_v_q  <= '0;
      pend_ht_q <= '0;
      pend_vt_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cfg.cfg_valid) begin
            if (set_ok) begin
              pend_h_q  <= cfg.cfg_h[4*CW-1:CW];
              pend_v_q  <= cfg.cfg_v[4*CW-1:CW];
              pend_ht_q <= h_sum[CW-1:0];
              pend_vt_q <= v_sum[CW-1:0];
              state_q   <= StPend;
              ready_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StPend: begin
          // Counters wrap to (0,0) on this same edge, so the new frame starts clean.
          if (frame_last) begin
            {ha_q, hf_q, hs_q} <= pend_h_q;
            {va_q, vf_q, vs_q} <= pend_v_q;
            ht_q    <= pend_ht_q;
            vt_q    <= pend_vt_q;
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [CW-1:0] hs_start, hs_end, vs_start, vs_end;
  logic          hs_raw, vs_raw, act_raw;
  logic [5:0]    raw_vec, out_vec;

  assign hs_start = ha_q + hf_q;
  assign hs_end   = hs_start + hs_q;
  assign vs_start = va_q + vf_q;
  assign vs_end   = vs_start + vs_q;
  assign hs_raw   = (hcnt_q >= hs_start) && (hcnt_q < hs_end);
  assign vs_raw   = (vcnt_q >= vs_start) && (vcnt_q < vs_end);
  assign act_raw  = (hcnt_q < ha_q) && (vcnt_q < va_q);
  assign raw_vec  = {hs_raw ~^ HSYNC_POL, vs_raw ~^ VSYNC_POL, ~(hs_raw | vs_raw), act_raw,
                     hcnt_q == '0, (hcnt_q == '0) && (vcnt_q == '0)};

  if (PIPE == 0) begin : g_comb
    assign out_vec = raw_vec;
  end else begin : g_pipe
    logic [5:0] pipe_q [PIPE];
    always_ff @(posedge vgaclk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIPE; i++) pipe_q[i] <= IdleVec;
      end else begin
        pipe_q[0] <= raw_vec;
        for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign out_vec = pipe_q[PIPE-1];
  end

  assign {hsync, vsync, sync_b, blank_b, line_start, frame_start} = out_vec;
  assign hcnt          = hcnt_q;
  assign vcnt          = vcnt_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

endmodule
